// File: rtl/axi_wr_txn_tracker.sv
// -----------------------------------------------------------------------------
// axi_wr_txn_tracker
// Tracks outstanding AXI write transactions from AW acceptance through W-last
// to B retirement. Entries are kept in a compacting ordered list, with slot 0
// holding the oldest entry and valid slots occupying 0..count-1.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   awid/awvalid/awready/awuser   AW channel (awuser carries the txn type)
//   wid/wvalid/wready/wlast       W channel
//   bid/bvalid/bready             B channel
//   to_block            router veto on AW insertion
//   release_ready       special-release memory accepts a DIVERT release
//   err_clr             clears the sticky b_orphan flag
//   count               number of occupied slots (registered)
//   full/empty/almost_full        occupancy flags decoded from count
//   block_data          current W beat has no open matching entry
//   block_fin           one-cycle pulse after a BLOCK-type retirement
//   spec_release        DIVERT release request, held until accepted
//   b_orphan            sticky: a B arrived with no retirable entry
// -----------------------------------------------------------------------------
module axi_wr_txn_tracker #(
  parameter int                SLOTS       = 9,
  parameter int                ID_W        = 4,
  parameter int                USER_W      = 2,
  parameter logic [USER_W-1:0] BLOCK_CODE  = 2'b01,
  parameter logic [USER_W-1:0] DIVERT_CODE = 2'b10,
  parameter int                AF_MARGIN   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ID_W-1:0]              awid,
  input  logic                         awvalid,
  input  logic                         awready,
  input  logic [USER_W-1:0]            awuser,
  input  logic [ID_W-1:0]              wid,
  input  logic                         wvalid,
  input  logic                         wready,
  input  logic                         wlast,
  input  logic [ID_W-1:0]              bid,
  input  logic                         bvalid,
  input  logic                         bready,
  input  logic                         to_block,
  input  logic                         release_ready,
  input  logic                         err_clr,
  output logic [$clog2(SLOTS+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         block_data,
  output logic                         block_fin,
  output logic                         spec_release,
  output logic                         b_orphan
);

  localparam int CNT_W = $clog2(SLOTS + 1);
  localparam int IDX_W = $clog2(SLOTS);
  localparam logic [CNT_W-1:0] SLOTS_C = CNT_W'(SLOTS);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(SLOTS - AF_MARGIN);

  logic [ID_W-1:0]   id_q   [SLOTS];
  logic [ID_W-1:0]   id_d   [SLOTS];
  logic [USER_W-1:0] typ_q  [SLOTS];
  logic [USER_W-1:0] typ_d  [SLOTS];
  logic              done_q [SLOTS];
  logic              done_d [SLOTS];
  logic [CNT_W-1:0]  count_q, count_d;
  logic              block_fin_q, block_fin_d;
  logic              spec_release_q, spec_release_d;
  logic              b_orphan_q, b_orphan_d;

  logic              w_hit, b_hit;
  logic [IDX_W-1:0]  w_idx, b_idx;
  logic              ins, ret, dset, b_hs;
  logic [CNT_W-1:0]  ins_pos;

  // Lowest-index searches: descending scan so the lowest match is written last
  always_comb begin
    w_hit = 1'b0;
    w_idx = {IDX_W{1'b0}};
    b_hit = 1'b0;
    b_idx = {IDX_W{1'b0}};
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if ((CNT_W'(i) < count_q) && (id_q[i] == wid) && !done_q[i]) begin
        w_hit = 1'b1;
        w_idx = IDX_W'(i);
      end else begin
        w_hit = w_hit;
        w_idx = w_idx;
      end
      if ((CNT_W'(i) < count_q) && (id_q[i] == bid) && done_q[i]) begin
        b_hit = 1'b1;
        b_idx = IDX_W'(i);
      end else begin
        b_hit = b_hit;
        b_idx = b_idx;
      end
    end
  end

  // Event decode and next-state list update (done-set, then shift, then tail write)
  always_comb begin
    ins     = awvalid & awready & ~full & ~to_block;
    b_hs    = bvalid & bready;
    ret     = b_hs & b_hit;
    dset    = wvalid & wready & wlast & w_hit;
    id_d    = id_q;
    typ_d   = typ_q;
    done_d  = done_q;
    // w_idx and b_idx can never coincide: one requires done=0, the other done=1
    done_d[w_idx] = done_d[w_idx] | dset;
    for (int i = 0; i < SLOTS - 1; i++) begin
      if (ret && (IDX_W'(i) >= b_idx)) begin
        id_d[i]   = id_d[i+1];
        typ_d[i]  = typ_d[i+1];
        done_d[i] = done_d[i+1];
      end else begin
        id_d[i]   = id_d[i];
        typ_d[i]  = typ_d[i];
        done_d[i] = done_d[i];
      end
    end
    if (ret) begin
      done_d[SLOTS-1] = 1'b0;
    end else begin
      done_d[SLOTS-1] = done_d[SLOTS-1];
    end
    // Tail position after any retirement; ins implies count_q < SLOTS
    ins_pos = count_q - {{(CNT_W-1){1'b0}}, ret};
    if (ins) begin
      id_d[ins_pos[IDX_W-1:0]]   = awid;
      typ_d[ins_pos[IDX_W-1:0]]  = awuser;
      done_d[ins_pos[IDX_W-1:0]] = 1'b0;
    end else begin
      id_d   = id_d;
      typ_d  = typ_d;
      done_d = done_d;
    end
    count_d = count_q + {{(CNT_W-1){1'b0}}, ins} - {{(CNT_W-1){1'b0}}, ret};

    block_fin_d = ret & (typ_q[b_idx] == BLOCK_CODE);
    // Retiring the head exposes slot 1 as the new head; a DIVERT there is released
    if (ret && (b_idx == {IDX_W{1'b0}}) && (count_q >= CNT_W'(2)) &&
        (typ_q[1] == DIVERT_CODE)) begin
      spec_release_d = 1'b1;
    end else if (release_ready) begin
      spec_release_d = 1'b0;
    end else begin
      spec_release_d = spec_release_q;
    end
    if (b_hs && !b_hit) begin
      b_orphan_d = 1'b1;
    end else if (err_clr) begin
      b_orphan_d = 1'b0;
    end else begin
      b_orphan_d = b_orphan_q;
    end
  end

  // State registers with asynchronous clear of every entry and flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) begin
        id_q[i]   <= {ID_W{1'b0}};
        typ_q[i]  <= {USER_W{1'b0}};
        done_q[i] <= 1'b0;
      end
      count_q        <= {CNT_W{1'b0}};
      block_fin_q    <= 1'b0;
      spec_release_q <= 1'b0;
      b_orphan_q     <= 1'b0;
    end else begin
      id_q           <= id_d;
      typ_q          <= typ_d;
      done_q         <= done_d;
      count_q        <= count_d;
      block_fin_q    <= block_fin_d;
      spec_release_q <= spec_release_d;
      b_orphan_q     <= b_orphan_d;
    end
  end

  // Output decode from registered state
  always_comb begin
    count        = count_q;
    full         = (count_q == SLOTS_C);
    empty        = (count_q == {CNT_W{1'b0}});
    almost_full  = (count_q >= AF_C);
    block_data   = wvalid & ~w_hit;
    block_fin    = block_fin_q;
    spec_release = spec_release_q;
    b_orphan     = b_orphan_q;
  end

endmodule

// File: tb/tb_axi_wr_txn_tracker.sv
// -----------------------------------------------------------------------------
// tb_axi_wr_txn_tracker
// Directed, table-driven bench for axi_wr_txn_tracker (SLOTS=9 defaults).
// Each vector holds one cycle of inputs plus the expected combinational
// block_data before the edge and the expected registered outputs after it.
// -----------------------------------------------------------------------------
module tb_axi_wr_txn_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] awid, wid, bid;
  logic [1:0] awuser;
  logic       awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic       to_block, release_ready, err_clr;
  logic [3:0] count;
  logic       full, empty, almost_full, block_data, block_fin, spec_release, b_orphan;

  int checks   = 0;
  int failures = 0;

  axi_wr_txn_tracker dut (
    .clk(clk), .rst_n(rst_n),
    .awid(awid), .awvalid(awvalid), .awready(awready), .awuser(awuser),
    .wid(wid), .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .bid(bid), .bvalid(bvalid), .bready(bready),
    .to_block(to_block), .release_ready(release_ready), .err_clr(err_clr),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .block_data(block_data), .block_fin(block_fin),
    .spec_release(spec_release), .b_orphan(b_orphan)
  );

  always #5 clk = ~clk;

  typedef struct {
    int aw, awid, awu, w, wid, wl, b, bid, tob, rr, ec, rdy;
    int e_bd, e_cnt, e_bf, e_sr, e_or;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(int aw, int awid_i, int awu, int w, int wid_i, int wl,
                              int b, int bid_i, int tob, int rr, int ec, int rdy,
                              int e_bd, int e_cnt, int e_bf, int e_sr, int e_or);
    vec_t v;
    v.aw = aw; v.awid = awid_i; v.awu = awu; v.w = w; v.wid = wid_i; v.wl = wl;
    v.b = b; v.bid = bid_i; v.tob = tob; v.rr = rr; v.ec = ec; v.rdy = rdy;
    v.e_bd = e_bd; v.e_cnt = e_cnt; v.e_bf = e_bf; v.e_sr = e_sr; v.e_or = e_or;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    awvalid = 1'b0; awid = 4'd0; awuser = 2'd0; awready = 1'b1;
    wvalid = 1'b0; wid = 4'd0; wlast = 1'b0; wready = 1'b1;
    bvalid = 1'b0; bid = 4'd0; bready = 1'b1;
    to_block = 1'b0; release_ready = 1'b0; err_clr = 1'b0;
  endtask

  task automatic chk_regs(input string tag, input int cnt, input int bf, input int sr, input int orph);
    chk({tag, "_count"}, int'(count), cnt);
    chk({tag, "_full"}, int'(full), (cnt == 9) ? 1 : 0);
    chk({tag, "_empty"}, int'(empty), (cnt == 0) ? 1 : 0);
    chk({tag, "_afull"}, int'(almost_full), (cnt >= 8) ? 1 : 0);
    chk({tag, "_block_fin"}, int'(block_fin), bf);
    chk({tag, "_spec_release"}, int'(spec_release), sr);
    chk({tag, "_b_orphan"}, int'(b_orphan), orph);
  endtask

  task automatic run_vec(input vec_t v, input int n);
    string tag;
    tag = $sformatf("v%0d", n);
    awvalid = 1'(v.aw); awid = 4'(v.awid); awuser = 2'(v.awu);
    wvalid = 1'(v.w); wid = 4'(v.wid); wlast = 1'(v.wl);
    bvalid = 1'(v.b); bid = 4'(v.bid);
    to_block = 1'(v.tob); release_ready = 1'(v.rr); err_clr = 1'(v.ec);
    awready = 1'(v.rdy); wready = 1'(v.rdy); bready = 1'(v.rdy);
    #1;
    chk({tag, "_block_data"}, int'(block_data), v.e_bd);
    @(posedge clk);
    #1;
    chk_regs(tag, v.e_cnt, v.e_bf, v.e_sr, v.e_or);
    drive_idle();
  endtask

  initial begin
    // mk(aw,awid,awu, w,wid,wl, b,bid, tob,rr,ec,rdy, bd,cnt,bf,sr,orph)
    // Fill to full, overflow attempt, complete all, retire with a same-cycle AW
    for (int k = 0; k < 9; k++) vq.push_back(mk(1,k,0, 0,0,0, 0,0, 0,0,0,1, 0,k+1,0,0,0));
    vq.push_back(mk(1,9,0, 0,0,0, 0,0, 0,0,0,1, 0,9,0,0,0));
    for (int k = 0; k < 9; k++) vq.push_back(mk(0,0,0, 1,k,1, 0,0, 0,0,0,1, 0,9,0,0,0));
    vq.push_back(mk(1,9,0, 0,0,0, 1,0, 0,0,0,1, 0,8,0,0,0));
    for (int k = 1; k < 9; k++) vq.push_back(mk(0,0,0, 0,0,0, 1,k, 0,0,0,1, 0,8-k,0,0,0));
    // Veto and not-ready AW, then single txn life cycle
    vq.push_back(mk(1,7,0, 0,0,0, 0,0, 1,0,0,1, 0,0,0,0,0));
    vq.push_back(mk(1,7,0, 0,0,0, 0,0, 0,0,0,0, 0,0,0,0,0));
    vq.push_back(mk(1,3,0, 0,0,0, 0,0, 0,0,0,1, 0,1,0,0,0));
    vq.push_back(mk(0,0,0, 1,3,1, 0,0, 0,0,0,1, 0,1,0,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 1,3, 0,0,0,1, 0,0,0,0,0));
    // Unmatched W, orphan B, sticky flag, clear, set-beats-clear
    vq.push_back(mk(0,0,0, 1,5,0, 0,0, 0,0,0,1, 1,0,0,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 1,5, 0,0,0,1, 0,0,0,0,1));
    vq.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0,1, 0,0,0,0,1));
    vq.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,1,1, 0,0,0,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 1,5, 0,0,1,1, 0,0,0,0,1));
    vq.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,1,1, 0,0,0,0,0));
    // Non-last beat leaves done clear, so B before W-last is an orphan
    vq.push_back(mk(1,3,0, 0,0,0, 0,0, 0,0,0,1, 0,1,0,0,0));
    vq.push_back(mk(0,0,0, 1,3,0, 0,0, 0,0,0,1, 0,1,0,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 1,3, 0,0,0,1, 0,1,0,0,1));
    vq.push_back(mk(0,0,0, 1,3,1, 0,0, 0,0,1,1, 0,1,0,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 1,3, 0,0,0,1, 0,0,0,0,0));
    // {id1 done, id2, id3}; retire id1 + AW id4 + W-last id3 in one cycle
    vq.push_back(mk(1,1,0, 0,0,0, 0,0, 0,0,0,1, 0,1,0,0,0));
    vq.push_back(mk(0,0,0, 1,1,1, 0,0, 0,0,0,1, 0,1,0,0,0));
    vq.push_back(mk(1,2,0, 0,0,0, 0,0, 0,0,0,1, 0,2,0,0,0));
    vq.push_back(mk(1,3,0, 0,0,0, 0,0, 0,0,0,1, 0,3,0,0,0));
    vq.push_back(mk(1,4,0, 1,3,1, 1,1, 0,0,0,1, 0,3,0,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 1,3, 0,0,0,1, 0,2,0,0,0));
    vq.push_back(mk(0,0,0, 1,2,1, 0,0, 0,0,0,1, 0,2,0,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 1,2, 0,0,0,1, 0,1,0,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 1,4, 0,0,0,1, 0,1,0,0,1));
    vq.push_back(mk(0,0,0, 1,4,1, 0,0, 0,0,1,1, 0,1,0,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 1,4, 0,0,0,1, 0,0,0,0,0));
    // DIVERT release: hold until release_ready, then set-beats-clear
    vq.push_back(mk(1,1,0, 0,0,0, 0,0, 0,0,0,1, 0,1,0,0,0));
    vq.push_back(mk(0,0,0, 1,1,1, 0,0, 0,0,0,1, 0,1,0,0,0));
    vq.push_back(mk(1,6,2, 0,0,0, 0,0, 0,0,0,1, 0,2,0,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 1,1, 0,0,0,1, 0,1,0,1,0));
    vq.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0,1, 0,1,0,1,0));
    vq.push_back(mk(0,0,0, 0,0,0, 0,0, 0,1,0,1, 0,1,0,0,0));
    vq.push_back(mk(1,7,2, 0,0,0, 0,0, 0,0,0,1, 0,2,0,0,0));
    vq.push_back(mk(0,0,0, 1,6,1, 0,0, 0,0,0,1, 0,2,0,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 1,6, 0,1,0,1, 0,1,0,1,0));
    vq.push_back(mk(0,0,0, 0,0,0, 0,0, 0,1,0,1, 0,1,0,0,0));
    vq.push_back(mk(0,0,0, 1,7,1, 0,0, 0,0,0,1, 0,1,0,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 1,7, 0,0,0,1, 0,0,0,0,0));
    // BLOCK retirement pulses block_fin for one cycle
    vq.push_back(mk(1,2,1, 0,0,0, 0,0, 0,0,0,1, 0,1,0,0,0));
    vq.push_back(mk(0,0,0, 1,2,1, 0,0, 0,0,0,1, 0,1,0,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 1,2, 0,0,0,1, 0,0,1,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0,1, 0,0,0,0,0));
    // Build state with every flag set, ahead of a mid-list reset
    vq.push_back(mk(1,1,0, 0,0,0, 0,0, 0,0,0,1, 0,1,0,0,0));
    vq.push_back(mk(1,2,2, 0,0,0, 0,0, 0,0,0,1, 0,2,0,0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 1,9, 0,0,0,1, 0,2,0,0,1));
    vq.push_back(mk(0,0,0, 1,1,1, 0,0, 0,0,0,1, 0,2,0,0,1));
    vq.push_back(mk(1,3,1, 0,0,0, 1,1, 0,0,0,1, 0,2,0,1,1));

    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_regs("reset", 0, 0, 0, 0);
    chk("reset_block_data", int'(block_data), 0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_regs("post_reset", 0, 0, 0, 0);

    for (int n = 0; n < vq.size(); n++) run_vec(vq[n], n);

    // Asynchronous reset mid-list: outputs clear without waiting for an edge
    #2 rst_n = 1'b0;
    #1;
    chk_regs("async_rst", 0, 0, 0, 0);
    chk("async_rst_block_data", int'(block_data), 0);
    @(posedge clk);
    #1;
    chk_regs("rst_held", 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Discarded entries must not match, and the list works again from empty
    run_vec(mk(0,0,0, 1,3,0, 0,0, 0,0,0,1, 1,0,0,0,0), 1000);
    run_vec(mk(1,5,0, 0,0,0, 0,0, 0,0,0,1, 0,1,0,0,0), 1001);
    run_vec(mk(0,0,0, 1,5,0, 0,0, 0,0,0,1, 0,1,0,0,0), 1002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
